// File: rtl/uart_rx_fifo_writer.sv
// UART receiver (16x oversampled, optional parity) feeding the write side
// of a dual-clock FIFO; pushes one winc per good character, gated by wfull.
//
// Ports:
//   wclk, wrst_n         write-domain clock, async active-low reset
//   rx                   async serial line, idle high
//   baud_div             wclk cycles per oversample tick (0 acts as 1)
//   parity_en/odd        parity bit present / odd (1) or even (0)
//   wfull                FIFO full flag
//   winc, wdata          one-cycle FIFO write strobe and character
//   frame_err            pulse: stop bit sampled low
//   parity_err           pulse: parity mismatch
//   overrun              pulse: good character dropped on wfull
//   busy                 receiver not idle
module uart_rx_fifo_writer #(
  parameter int DSIZE     = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 rx,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 wfull,
  output logic                 winc,
  output logic [DSIZE-1:0]     wdata,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int BW = (DSIZE > 1) ? $clog2(DSIZE) : 1;
  localparam logic [BW-1:0] BLAST = BW'(DSIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t state_q, state_d;

  logic                 rx_q1, rx_s;
  logic [DIV_WIDTH-1:0] presc, div_m1;
  logic                 tick;
  logic [3:0]           scnt;
  logic [BW-1:0]        bcnt;
  logic [DSIZE-1:0]     shreg;
  logic [DSIZE-1:0]     wdata_q;
  logic                 perr;
  logic                 stop_hit;
  logic                 stop_bit;
  logic                 samp8, samp16;
  logic                 enter, to_start;

  assign div_m1 = (baud_div == '0) ? '0 : baud_div - DIV_WIDTH'(1);
  // >= keeps the prescaler sane if baud_div shrinks while idle
  assign tick   = (presc >= div_m1);
  assign samp8  = tick && (scnt == 4'd7);
  assign samp16 = tick && (scnt == 4'd15);

  assign enter    = (state_d != state_q);
  assign to_start = (state_q == IDLE) && (state_d == START);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q  <= IDLE;
      presc    <= '0;
      scnt     <= '0;
      bcnt     <= '0;
      shreg    <= '0;
      wdata_q  <= '0;
      perr     <= 1'b0;
      stop_hit <= 1'b0;
      stop_bit <= 1'b1;
    end else begin
      state_q <= state_d;

      // tick phase restarts at the detected start edge
      if (to_start || tick) presc <= '0;
      else                  presc <= presc + DIV_WIDTH'(1);

      if (enter)     scnt <= '0;
      else if (tick) scnt <= scnt + 4'd1;

      if (state_d == DATA && enter)
        bcnt <= '0;
      else if (state_q == DATA && samp16)
        bcnt <= bcnt + BW'(1);

      if (state_q == DATA && samp16)
        shreg <= {rx_s, shreg[DSIZE-1:1]};

      if (to_start)
        perr <= 1'b0;
      else if (state_q == PARITY && samp16)
        perr <= (rx_s != (^shreg ^ parity_odd));

      // stop is sampled on its tick and resolved the cycle after
      stop_hit <= (state_q == STOP) && samp16 && !stop_hit;
      if (state_q == STOP && samp16 && !stop_hit)
        stop_bit <= rx_s;

      if (winc) wdata_q <= shreg;
    end
  end

  always_comb begin
    state_d    = state_q;
    winc       = 1'b0;
    frame_err  = 1'b0;
    parity_err = 1'b0;
    overrun    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        if (samp8) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (samp16 && bcnt == BLAST)
          state_d = parity_en ? PARITY : STOP;
      end
      PARITY: begin
        if (samp16) state_d = STOP;
      end
      STOP: begin
        if (stop_hit) begin
          if (!stop_bit) begin
            frame_err = 1'b1;
            state_d   = WAIT_HIGH;
          end else if (perr) begin
            parity_err = 1'b1;
            state_d    = IDLE;
          end else if (wfull) begin
            overrun = 1'b1;
            state_d = IDLE;
          end else begin
            winc    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wdata = winc ? shreg : wdata_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Bench for uart_rx_fifo_writer: directed frames, expected-event queue
// model and a per-cycle compare process.
module tb_uart_rx_fifo_writer;

  logic        wclk = 1'b0;
  logic        wrst_n = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        wfull = 1'b0;
  logic        winc;
  logic [7:0]  wdata;
  logic        frame_err;
  logic        parity_err;
  logic        overrun;
  logic        busy;

  uart_rx_fifo_writer #(.DSIZE(8), .DIV_WIDTH(16)) dut (
    .wclk(wclk),
    .wrst_n(wrst_n),
    .rx(rx),
    .baud_div(baud_div),
    .parity_en(parity_en),
    .parity_odd(parity_odd),
    .wfull(wfull),
    .winc(winc),
    .wdata(wdata),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 wclk = ~wclk;

  typedef enum int {K_WRITE, K_FRAME, K_PAR, K_OVR} kind_t;
  typedef struct {
    kind_t      kind;
    logic [7:0] data;
  } evt_t;

  evt_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         pulses = 0;
  int         last_cyc = 0;
  int         t_fall = 0;
  kind_t      last_kind = K_WRITE;
  logic [7:0] last_data = 8'h00;
  logic [7:0] hold_exp = 8'h00;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h need %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge wclk);
    #1;
  endtask

  function automatic int blen();
    return 16 * ((baud_div == 16'd0) ? 1 : int'(baud_div));
  endfunction

  // Outcome of a frame from the line-level rules: stop, parity, full.
  function automatic evt_t predict(logic [7:0] d, bit pbit, bit stop);
    evt_t e;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    e.data = d;
    if (!stop)
      e.kind = K_FRAME;
    else if (parity_en && (pbit != ((ones % 2 == 1) ^ parity_odd)))
      e.kind = K_PAR;
    else if (wfull)
      e.kind = K_OVR;
    else
      e.kind = K_WRITE;
    return e;
  endfunction

  task automatic send(logic [7:0] d, bit pbit, bit stop, int extra);
    exp_q.push_back(predict(d, pbit, stop));
    rx = 1'b0;
    t_fall = cyc;
    tick(blen());
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(blen());
    end
    if (parity_en) begin
      rx = pbit;
      tick(blen());
    end
    rx = stop;
    tick(blen());
    if (extra > 0) tick(extra);
  endtask

  int p0;

  initial begin
    fork
      begin
        forever begin
          int    n;
          kind_t k;
          evt_t  e;
          @(negedge wclk);
          cyc++;
          if (!wrst_n) begin
            hold_exp = 8'h00;
          end else begin
            n = int'(winc) + int'(frame_err) + int'(parity_err) + int'(overrun);
            if (winc) chk("winc_while_full", wfull, 0);
            if (n > 1) chk("pulses_per_cycle", n, 1);
            if (n >= 1) begin
              k = winc ? K_WRITE : frame_err ? K_FRAME :
                  parity_err ? K_PAR : K_OVR;
              pulses++;
              last_cyc = cyc;
              last_kind = k;
              chk("pulse_expected", exp_q.size() > 0, 1);
              if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pulse_kind", k, e.kind);
                if (winc) begin
                  chk("wdata", wdata, e.data);
                  hold_exp = e.data;
                  last_data = wdata;
                end
              end
            end
            if (!winc) chk("wdata_hold", wdata, hold_exp);
          end
        end
      end
    join_none

    // reset state
    wrst_n = 1'b0;
    tick(3);
    chk("rst_winc", winc, 0);
    chk("rst_wdata", wdata, 8'h00);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    wrst_n = 1'b1;
    tick(5);

    // 1: plain 8N1 at baud_div=4
    p0 = pulses;
    send(8'hA5, 1'b0, 1'b1, 0);
    tick(10);
    chk("t1_pulses", pulses - p0, 1);
    chk("t1_kind", last_kind, K_WRITE);
    chk("t1_data", last_data, 8'hA5);
    chk("t1_lat_ok", (last_cyc - t_fall >= 608) && (last_cyc - t_fall <= 616), 1);
    chk("t1_busy", busy, 0);

    // 2: start glitch
    p0 = pulses;
    rx = 1'b0;
    tick(10);
    chk("t2_busy_on", busy, 1);
    tick(10);
    rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      tick(1);
    end
    chk("t2_busy_off", busy, 0);
    chk("t2_pulses", pulses - p0, 0);
    tick(20);

    // 3: even parity good then bad
    parity_en = 1'b1;
    parity_odd = 1'b0;
    p0 = pulses;
    send(8'h37, 1'b1, 1'b1, 10);
    chk("t3_kind_ok", last_kind, K_WRITE);
    chk("t3_data", last_data, 8'h37);
    send(8'h37, 1'b0, 1'b1, 10);
    chk("t3_kind_bad", last_kind, K_PAR);
    chk("t3_pulses", pulses - p0, 2);
    chk("t3_hold", wdata, 8'h37);
    parity_en = 1'b0;

    // 4: framing error then break
    p0 = pulses;
    send(8'h5A, 1'b0, 1'b0, 2000);
    chk("t4_pulses", pulses - p0, 1);
    chk("t4_kind", last_kind, K_FRAME);
    chk("t4_busy_break", busy, 1);
    rx = 1'b1;
    tick(6);
    chk("t4_busy_off", busy, 0);
    tick(20);

    // 5: overrun then normal write
    wfull = 1'b1;
    p0 = pulses;
    send(8'h11, 1'b0, 1'b1, 10);
    chk("t5_kind_ovr", last_kind, K_OVR);
    wfull = 1'b0;
    send(8'h22, 1'b0, 1'b1, 10);
    chk("t5_kind_wr", last_kind, K_WRITE);
    chk("t5_data", last_data, 8'h22);
    chk("t5_pulses", pulses - p0, 2);

    // baud_div of zero runs at one cycle per tick
    baud_div = 16'd0;
    tick(5);
    p0 = pulses;
    send(8'hC3, 1'b0, 1'b1, 10);
    chk("div0_pulses", pulses - p0, 1);
    chk("div0_data", last_data, 8'hC3);
    chk("div0_lat_ok", (last_cyc - t_fall >= 152) && (last_cyc - t_fall <= 158), 1);
    baud_div = 16'd4;
    tick(20);

    // 6: back-to-back frames, then reset mid-frame
    p0 = pulses;
    send(8'h00, 1'b0, 1'b1, 0);
    send(8'hFF, 1'b0, 1'b1, 0);
    send(8'h81, 1'b0, 1'b1, 0);
    chk("t6_pulses", pulses - p0, 3);
    chk("t6_last", last_data, 8'h81);
    rx = 1'b0;
    tick(blen());
    rx = 1'b1;
    tick(blen());
    rx = 1'b0;
    tick(blen());
    chk("t6_busy_mid", busy, 1);
    wrst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_wdata", wdata, 8'h00);
    chk("t6_rst_winc", winc, 0);
    chk("t6_rst_errs", {frame_err, parity_err, overrun}, 0);
    rx = 1'b1;
    tick(3);
    wrst_n = 1'b1;
    tick(50);
    chk("t6_pulses_after", pulses - p0, 3);
    chk("t6_busy_after", busy, 0);
    chk("t6_wdata_after", wdata, 8'h00);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo_writer.md
Name: uart_rx_fifo_writer

Overview:
UART receive deserializer in the write-clock domain that produces the write side of the dual-clock FIFO. It oversamples the asynchronous rx line at 16x a programmable baud rate and checks start, parity and stop bits. Each valid character is pushed as a single-cycle winc/wdata write, gated by the FIFO's wfull. Errors and overruns are reported as single-cycle pulses for the status logic.

Parameters:
DSIZE, 8, data bits per character; equals the FIFO DSIZE
DIV_WIDTH, 16, width of the baud prescaler divisor

Ports:
wclk  input  1  write-domain clock
wrst_n  input  1  reset, asynchronous, active-low
rx  input  1  asynchronous serial line, idle high
baud_div  input  DIV_WIDTH  wclk cycles per oversample tick; 0 is treated as 1; static while busy=1
parity_en  input  1  parity bit present after data; static while busy=1
parity_odd  input  1  1 = odd parity, 0 = even; static while busy=1
wfull  input  1  FIFO full flag, wclk domain
winc  output  1  one-cycle FIFO write strobe
wdata  output  DSIZE  received character; valid while winc=1
frame_err  output  1  one-cycle pulse: stop bit sampled low
parity_err  output  1  one-cycle pulse: parity mismatch
overrun  output  1  one-cycle pulse: valid character dropped because wfull=1
busy  output  1  high in every state except IDLE

Behaviour:
- Reset values: winc=0, wdata=0, frame_err=0, parity_err=0, overrun=0, busy=0. Sync flops reset to 1. FSM resets to IDLE. Prescaler, sample count, bit count and shift register reset to 0.
- Synchronizer: 2-flop sync of rx gives rx_s. All decisions use rx_s only.
- Prescaler: counts 0..max(baud_div,1)-1. It emits a one-cycle tick when it wraps. It is cleared on entry to START so the tick phase aligns to the start edge.
- Sample counter: 4-bit, counts ticks. It is cleared on each state entry.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE -> START when rx_s=0.
- START:
  - Sample rx_s on the 8th tick (mid start bit).
  - rx_s=1: glitch; go to IDLE with no output.
  - rx_s=0: go to DATA with bit count 0.
- DATA:
  - Sample rx_s on every 16th tick (mid-bit).
  - Shift LSB first: shreg <= {rx_s, shreg[DSIZE-1:1]}.
  - After DSIZE bits: go to PARITY if parity_en=1, else STOP.
- PARITY:
  - Sample on the 16th tick.
  - Expected bit = ^shreg ^ parity_odd.
  - Record whether the sample mismatches, then go to STOP.
- STOP: sample on the 16th tick, then resolve with this priority, one cycle after the sampling tick:
  - rx_s=0: frame_err=1; character discarded; go to WAIT_HIGH.
  - Parity mismatch recorded: parity_err=1; character discarded; go to IDLE.
  - wfull=1 (sampled in the same cycle as winc would assert): overrun=1; winc stays 0; go to IDLE.
  - Otherwise: winc=1 for exactly one cycle, with wdata=shreg in that same cycle; go to IDLE.
- WAIT_HIGH: stay until rx_s=1 (covers break condition), then go to IDLE. No further frame_err pulses during a break.
- Between pushes, wdata holds the last pushed value.
- No winc is ever asserted while wfull=1. At most one output pulse per frame.
- Latency: the write occurs one wclk cycle after the mid-stop-bit tick, about (9.5 + parity_en) × 16 × baud_div cycles after the falling edge, plus 3 cycles for sync and detect.
- Back-to-back frames: IDLE is reached at mid-stop, so a start edge arriving half a bit later is detected.
- wrst_n asserted mid-frame: immediate return to IDLE; the partial character is lost and no pulses are generated.

Test Plan:
1. baud_div=4, parity_en=0, wfull=0; send 0xA5 with 1 stop bit (64 cycles/bit) -> exactly one winc pulse with wdata=0xA5, within 608..616 cycles of the rx falling edge; no error pulses.
2. Same setup; rx low pulse of 20 cycles, then high -> no winc, no errors; busy returns to 0 within 40 cycles.
3. parity_en=1, parity_odd=0; send 0x37 with parity bit 1 (correct even parity) -> winc with wdata=0x37. Repeat with parity bit 0 -> parity_err pulse only, no winc.
4. Send 0x5A with stop bit 0, then hold rx low for 2000 cycles -> exactly one frame_err pulse, no winc; busy stays 1 until rx returns high.
5. Hold wfull=1; send 0x11 -> overrun pulse, winc never asserted. Drop wfull to 0 and send 0x22 -> winc with wdata=0x22.
6. Three back-to-back frames 0x00, 0xFF, 0x81 (no idle gap); then assert wrst_n low mid-way through a fourth frame -> three winc pulses in order; the fourth produces no output; all outputs return to reset values.
